piso_tx_ctrl: RTL and testbench
===============================

Name: piso_tx_ctrl

Overview:
Sequencer that feeds parallel words into an internal parallel-in/serial-out shift register and streams them out one bit per cycle.
Accepts words over a valid/ready handshake into a one-word holding buffer, so back-to-back words stream with no bubble.
Generates the load/shift sequencing, bit counting, frame-start marker, end-of-word pulse and optional inter-word gap.
Sits between a word-oriented producer and a bit-serial link.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
GAP, 0, idle cycles inserted after each word; ser_valid is low during the gap.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  producer has a word on in_data.
in_ready  out  1  holding buffer can accept a word.
in_data  in  WIDTH  parallel word.
flush  in  1  synchronous abort of buffered and in-flight data.
ser_out  out  1  serial data bit.
ser_valid  out  1  ser_out carries a data bit this cycle.
ser_first  out  1  high on the first bit of each word.
word_done  out  1  high on the last bit of each word.
busy  out  1  high when the FSM is not in IDLE or the buffer is full.

Behaviour:
- Reset (async, rst=1): state IDLE, buffer empty, shreg 0, counters 0, ser_out/ser_valid/ser_first/word_done/busy = 0, in_ready = 0. in_ready is 1 from the first cycle after rst deasserts.
- Handshake: transfer occurs on a rising edge with in_valid & in_ready; in_data is captured into the buffer and buf_full is set. in_ready = !buf_full & !flush & !rst. It is registered-state based and has no combinational path from in_valid.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: if buf_full, then on the next edge load shreg from the buffer, clear buf_full, set bit_cnt = WIDTH-1, and go to SHIFT.
- Latency: a word accepted at edge k has its first bit valid in the cycle after edge k+1.
- SHIFT: ser_valid = 1. ser_out = shreg MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0). ser_first = 1 when bit_cnt == WIDTH-1. word_done = 1 when bit_cnt == 0. Each edge shifts shreg by one and decrements bit_cnt.
- SHIFT, edge with bit_cnt == 0:
  - GAP == 0 and buf_full: reload shreg, stay in SHIFT (zero bubble).
  - GAP > 0: go to GAP with gap_cnt = GAP-1.
  - Otherwise: go to IDLE.
- GAP: ser_valid = 0. Each edge decrements gap_cnt. At gap_cnt == 0, go to SHIFT (reload) if buf_full, else IDLE.
- Throughput: sustained 1 bit/cycle with GAP == 0. The buffer refills during a word because WIDTH >= 2.
- Outputs when ser_valid = 0: ser_out, ser_first and word_done are 0.
- flush: has priority over everything. On the edge it is sampled, the buffer is cleared, the state goes to IDLE and the outputs go to their reset values; any transfer in that cycle is ignored (in_ready is low). A flush mid-word truncates the word, and word_done is not issued for it.
- rst asserted mid-word: outputs clear immediately (async); no partial word resumes.
- Counter widths: bit_cnt is $clog2(WIDTH) bits; gap_cnt is max(1, $clog2(GAP+1)) bits. Counters never wrap below 0.

Decomposition:
- Package piso_tx_pkg: the state enum (IDLE, SHIFT, GAP) and a function computing counter widths.
- Sub-module piso_shreg: WIDTH-bit register with load, shift_en and MSB_FIRST, plus the async reset. The controller instantiates it and owns the FSM, buffer and counters.

Test Plan:
- Single word, in_data=8'hB1, MSB_FIRST=1, GAP=0 -> ser_out 1,0,1,1,0,0,0,1 on 8 consecutive ser_valid cycles starting 2 cycles after the transfer; ser_first on bit 0 only; word_done on bit 7 only; then IDLE, busy=0.
- Back-to-back 8'hB1 then 8'hAA with in_valid held high -> 16 contiguous ser_valid cycles (no bubble); second ser_first immediately after the first word_done; in_ready low whenever the buffer is full.
- GAP=3, two words 8'hF0, 8'h0F -> exactly 3 cycles with ser_valid=0 between words; bit sequence 11110000 then 00001111.
- MSB_FIRST=0, 8'hB1 -> ser_out 1,0,0,0,1,1,0,1.
- flush pulsed at the 4th bit of 8'hAA with 8'h55 buffered -> ser_valid low the next cycle, no word_done, 8'h55 discarded, in_ready=1 one cycle after flush drops.
- rst asserted mid-word for 1 cycle (async, off-edge) -> all outputs 0 immediately; a new word 8'hB1 after release streams correctly.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// ----------------------------------------------------------------------------
// piso_tx_pkg : shared state encoding and counter-width helper for piso_tx_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package piso_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Bits needed to count down from n-1 to 0, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shreg.sv
// ----------------------------------------------------------------------------
// piso_shreg : parallel-load shift register presenting one serial bit per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_bit
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign ser_bit   = shreg_q[WIDTH-1];
      assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign ser_bit   = shreg_q[0];
      assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (clr) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= load_data;
    end else if (shift_en) begin
      shreg_q <= w_shifted;
    end
  end

endmodule

`default_nettype wire

// File: rtl/piso_tx_ctrl.sv
// ----------------------------------------------------------------------------
// piso_tx_ctrl : word-to-serial sequencer with a one-word holding buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             word_done,
  output logic             busy
);

  localparam int              BW       = cnt_w(WIDTH);
  localparam int              GW       = cnt_w(GAP + 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full_q, buf_full_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             w_xfer, w_load, w_shift_en, w_ser_bit;

  assign in_ready   = !buf_full_q && !flush && !rst;
  assign w_xfer     = in_valid && in_ready;
  assign w_shift_en = (state_q == ST_SHIFT) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      if (w_xfer) begin
        buf_q <= in_data;
      end
      buf_full_q <= buf_full_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Reload from the buffer happens from IDLE, at the last bit (no gap) or at the end of a gap.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    w_load    = 1'b0;
    if (flush) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (buf_full_q) begin
            w_load    = 1'b1;
            bit_cnt_d = BIT_LAST;
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - BW'(1);
          end else if (GAP > 0) begin
            gap_cnt_d = GAP_LAST;
            state_d   = ST_GAP;
          end else if (buf_full_q) begin
            w_load    = 1'b1;
            bit_cnt_d = BIT_LAST;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GW'(1);
          end else if (buf_full_q) begin
            w_load    = 1'b1;
            bit_cnt_d = BIT_LAST;
            state_d   = ST_SHIFT;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (flush) begin
      buf_full_d = 1'b0;
    end else if (w_xfer) begin
      buf_full_d = 1'b1;
    end else if (w_load) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end
  end

  always_comb begin
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_first = 1'b0;
    word_done = 1'b0;
    busy      = (state_q != ST_IDLE) || buf_full_q;
    if (state_q == ST_SHIFT) begin
      ser_valid = 1'b1;
      ser_out   = w_ser_bit;
      ser_first = (bit_cnt_q == BIT_LAST);
      word_done = (bit_cnt_q == '0);
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .load      (w_load),
    .shift_en  (w_shift_en),
    .load_data (buf_q),
    .ser_bit   (w_ser_bit)
  );

endmodule

`default_nettype wire

// File: tb/tb_piso_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_piso_tx_ctrl : two instances (MSB-first/no gap, LSB-first/gap 3) checked
// against a word-schedule model. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_piso_tx_ctrl;

  localparam int W  = 8;
  localparam int NI = 2;

  // One accepted word: cycle accepted, first/last serial cycle, last busy cycle.
  typedef struct {
    int           inst;
    logic [W-1:0] data;
    int           acc;
    int           start;
    int           tend;
    int           gend;
  } wrec_t;

  typedef struct {
    int           inst;
    logic [W-1:0] data;
  } send_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush;
  logic [NI-1:0] in_valid, in_ready, ser_out, ser_valid, ser_first, word_done, busy;
  logic [W-1:0]  in_data [NI];

  wrec_t        sb[$];
  send_t        sendq[$];
  int           last_end [NI];
  int           cyc, checks, errors;
  bit           acc_now [NI];
  logic [W-1:0] data_now [NI];
  bit           fl_now;
  int           vprob, fprob, flush_req_off, flush_seen;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.WIDTH(W), .MSB_FIRST(1), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .flush(flush), .ser_out(ser_out[0]),
    .ser_valid(ser_valid[0]), .ser_first(ser_first[0]),
    .word_done(word_done[0]), .busy(busy[0])
  );

  piso_tx_ctrl #(.WIDTH(W), .MSB_FIRST(0), .GAP(3)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .flush(flush), .ser_out(ser_out[1]),
    .ser_valid(ser_valid[1]), .ser_first(ser_first[1]),
    .word_done(word_done[1]), .busy(busy[1])
  );

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic bit msb_of(input int i);
    return (i == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit exp_ready(input int i);
    if (rst || flush) return 1'b0;
    foreach (sb[n])
      if (sb[n].inst == i && sb[n].acc <= cyc && cyc < sb[n].start) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int find_word(input int i, input int c);
    for (int n = 0; n < sb.size(); n++)
      if (sb[n].inst == i && sb[n].start <= c && c <= sb[n].tend) return n;
    return -1;
  endfunction

  function automatic bit model_idle();
    foreach (sb[n]) if (sb[n].gend >= cyc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int i, input logic [W-1:0] d);
    send_t s;
    s.inst = i;
    s.data = d;
    sendq.push_back(s);
  endtask

  function automatic int count_send(input int i);
    int k = 0;
    foreach (sendq[n]) if (sendq[n].inst == i) k++;
    return k;
  endfunction

  task automatic front_send(input int i, output bit ok, output logic [W-1:0] d);
    ok = 1'b0;
    d  = '0;
    for (int n = 0; n < sendq.size(); n++)
      if (!ok && sendq[n].inst == i) begin
        ok = 1'b1;
        d  = sendq[n].data;
      end
  endtask

  task automatic pop_send(input int i);
    int idx = -1;
    for (int n = 0; n < sendq.size(); n++)
      if (idx < 0 && sendq[n].inst == i) idx = n;
    if (idx >= 0) sendq.delete(idx);
  endtask

  // Next word starts after its acceptance and after the previous word plus its gap.
  task automatic accept(input int i, input logic [W-1:0] d);
    wrec_t r;
    int    earliest;
    earliest = last_end[i] + 1 + gap_of(i);
    r.inst   = i;
    r.data   = d;
    r.acc    = cyc;
    r.start  = (cyc + 1 > earliest) ? cyc + 1 : earliest;
    r.tend   = r.start + W - 1;
    r.gend   = r.tend + gap_of(i);
    last_end[i] = r.tend;
    sb.push_back(r);
    pop_send(i);
  endtask

  task automatic edge_update();
    wrec_t r;
    if (fl_now) begin
      flush_seen++;
      for (int n = sb.size() - 1; n >= 0; n--) begin
        if (sb[n].start >= cyc) begin
          sb.delete(n);
        end else begin
          r = sb[n];
          if (r.tend > cyc - 1) r.tend = cyc - 1;
          if (r.gend > cyc - 1) r.gend = cyc - 1;
          sb[n] = r;
        end
      end
      for (int i = 0; i < NI; i++) last_end[i] = -100;
    end else begin
      for (int i = 0; i < NI; i++) if (acc_now[i]) accept(i, data_now[i]);
    end
    for (int n = sb.size() - 1; n >= 0; n--)
      if (sb[n].gend < cyc - 1) sb.delete(n);
  endtask

  task automatic drive();
    bit           ok;
    logic [W-1:0] d;
    int           n;
    flush = ($urandom_range(999) < fprob);
    if (flush_req_off >= 0) begin
      n = find_word(0, cyc);
      if (n >= 0 && cyc - sb[n].start == flush_req_off) begin
        flush         = 1'b1;
        flush_req_off = -1;
      end
    end
    for (int i = 0; i < NI; i++) begin
      front_send(i, ok, d);
      in_valid[i] = ok && ($urandom_range(99) < vprob);
      in_data[i]  = ok ? d : W'($urandom);
    end
  endtask

  task automatic check_cycle();
    int n, off;
    bit ev, eo, ef, ed, eb;
    for (int i = 0; i < NI; i++) begin
      n  = find_word(i, cyc);
      ev = (n >= 0);
      eo = 1'b0;
      ef = 1'b0;
      ed = 1'b0;
      eb = 1'b0;
      if (ev) begin
        off = cyc - sb[n].start;
        eo  = msb_of(i) ? sb[n].data[W-1-off] : sb[n].data[off];
        ef  = (off == 0);
        ed  = (off == W - 1);
      end
      foreach (sb[m])
        if (sb[m].inst == i && sb[m].acc <= cyc && cyc <= sb[m].gend) eb = 1'b1;
      check($sformatf("in_ready[%0d]", i),  32'(in_ready[i]),  32'(exp_ready(i)));
      check($sformatf("ser_valid[%0d]", i), 32'(ser_valid[i]), 32'(ev));
      check($sformatf("ser_out[%0d]", i),   32'(ser_out[i]),   32'(eo));
      check($sformatf("ser_first[%0d]", i), 32'(ser_first[i]), 32'(ef));
      check($sformatf("word_done[%0d]", i), 32'(word_done[i]), 32'(ed));
      check($sformatf("busy[%0d]", i),      32'(busy[i]),      32'(eb));
    end
  endtask

  task automatic capture();
    fl_now = flush;
    for (int i = 0; i < NI; i++) begin
      acc_now[i]  = in_valid[i] && exp_ready(i);
      data_now[i] = in_data[i];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    edge_update();
    #1 drive();
    @(negedge clk);
    check_cycle();
    capture();
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s in_ready[%0d]", tag, i),  32'(in_ready[i]),  32'd0);
      check($sformatf("%s ser_valid[%0d]", tag, i), 32'(ser_valid[i]), 32'd0);
      check($sformatf("%s ser_out[%0d]", tag, i),   32'(ser_out[i]),   32'd0);
      check($sformatf("%s ser_first[%0d]", tag, i), 32'(ser_first[i]), 32'd0);
      check($sformatf("%s word_done[%0d]", tag, i), 32'(word_done[i]), 32'd0);
      check($sformatf("%s busy[%0d]", tag, i),      32'(busy[i]),      32'd0);
    end
  endtask

  // Async reset asserted between edges, held across one edge, released off-edge.
  task automatic do_reset();
    #2;
    rst      = 1'b1;
    in_valid = '0;
    flush    = 1'b0;
    #1 check_zero("rst");
    sb.delete();
    for (int i = 0; i < NI; i++) begin
      last_end[i] = -100;
      acc_now[i]  = 1'b0;
    end
    fl_now = 1'b0;
    @(posedge clk);
    cyc++;
    #3 rst = 1'b0;
    @(negedge clk);
    check_cycle();
    capture();
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      if (sendq.size() == 0 && model_idle()) break;
      cycle();
    end
    check("wait_idle_bound", 32'(k < 400), 32'd1);
  endtask

  task automatic wait_offset(input int i, input int off);
    int k, n;
    bit hit;
    hit = 1'b0;
    for (k = 0; k < 60 && !hit; k++) begin
      cycle();
      n = find_word(i, cyc);
      if (n >= 0 && cyc - sb[n].start == off) hit = 1'b1;
    end
    check("wait_offset_bound", 32'(hit), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    flush         = 1'b0;
    in_valid      = '0;
    in_data[0]    = '0;
    in_data[1]    = '0;
    vprob         = 100;
    fprob         = 0;
    flush_req_off = -1;
    flush_seen    = 0;
    fl_now        = 1'b0;
    for (int i = 0; i < NI; i++) begin
      last_end[i] = -100;
      acc_now[i]  = 1'b0;
      data_now[i] = '0;
    end

    #1 rst = 1'b1;
    #2 check_zero("reset");
    @(posedge clk);
    cyc++;
    #3 rst = 1'b0;
    @(negedge clk);
    check_cycle();
    capture();

    // Single word, then back-to-back pair, then gap-separated pair.
    push(0, 8'hB1);
    push(1, 8'hB1);
    wait_idle();
    push(0, 8'hB1); push(0, 8'hAA);
    push(1, 8'hB1); push(1, 8'hAA);
    wait_idle();
    push(0, 8'hF0); push(0, 8'h0F);
    push(1, 8'hF0); push(1, 8'h0F);
    wait_idle();

    // Flush on the fourth bit of 8'hAA while 8'h55 sits in the buffer.
    flush_seen    = 0;
    flush_req_off = 3;
    push(0, 8'hAA); push(0, 8'h55);
    wait_idle();
    check("flush_fired", 32'(flush_seen), 32'd1);
    flush_req_off = -1;

    // Reset mid-word, then a fresh word on both instances.
    push(0, 8'hB1);
    wait_offset(0, 3);
    do_reset();
    sendq.delete();
    push(0, 8'hB1);
    push(1, 8'hB1);
    wait_idle();

    // Randomized traffic with occasional flushes.
    vprob = 70;
    fprob = 4;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++)
        if (count_send(i) < 2) push(i, W'($urandom));
      if (c == 1500) vprob = 100;
      cycle();
    end
    fprob = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
